pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and exception-PC capture. It replaces the fixed-width stall-less stage registers between decode/execute and later stages. It adds:
- backpressure with a registered `o_ready`
- guaranteed bubble (all-zero control) whenever the stage is empty or flushed
- capture of the oldest in-flight PC on flush, for the EPC path

## Interface

Parameters:
- `DATA_W`, default 95: payload width (imm 26 + busA 32 + busB 32 + Rw 5).
- `CTRL_W`, default 13: control width (EX 9 + M 3 + WB 1); forced to zero for bubbles.
- `PC_W`, default 32: PC width.
- `ZERO_DATA`, default 1: 1 = payload slots cleared to zero on flush/bubble; 0 = payload holds its last value.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: upstream has an instruction.
- `o_ready` out 1: stage can accept.
- `i_data` in DATA_W: upstream payload.
- `i_ctrl` in CTRL_W: upstream control.
- `i_pc` in PC_W: upstream PC.
- `o_valid` out 1: output slot holds an instruction.
- `i_ready` in 1: downstream accepts.
- `o_data` out DATA_W: output payload.
- `o_ctrl` out CTRL_W: output control; zero whenever `o_valid`=0.
- `o_pc` out PC_W: output PC.
- `i_flush` in 1: exception/mtc0 flush, synchronous.
- `o_epc` out PC_W: PC of the oldest valid entry at the last flush.
- `o_epc_valid` out 1: one-cycle pulse, cycle after a flush that discarded ≥1 valid entry.
- `o_count` out 2: occupancy, 0..2.

## Operation

- Storage: main slot (drives the outputs) plus skid slot. States:
  - EMPTY: count 0
  - ONE: main valid
  - TWO: main and skid valid
- `o_ready` = (state != TWO), decoded from the state register only; no combinational path from `i_ready`.
- Accept = `i_valid` & `o_ready`. Take = `o_valid` & `i_ready`.
- Transitions when `i_flush`=0:
  - EMPTY: accept → ONE, main ← input.
  - ONE: accept & !take → TWO, skid ← input. Take & !accept → EMPTY. Accept & take → ONE, main ← input. Neither → hold.
  - TWO: take → ONE, main ← skid. No take → hold. Accept is impossible because `o_ready`=0.
- Flush (highest priority, overrides accept and take):
  - Next state is EMPTY.
  - Input in the same cycle is discarded.
  - `o_ctrl` ← 0.
  - `o_data` ← 0 if `ZERO_DATA`=1.
  - `o_pc` holds.
  - If the state was non-EMPTY: `o_epc` ← main PC, and `o_epc_valid`=1 in the next cycle only.
- Empty slot: `o_ctrl`=0 always. `o_data`=0 when `ZERO_DATA`=1.
- Slot widths are exact parameter widths; no truncation or extension.

## Timing

- Reset (async assert, released synchronously by the surrounding design) sets:
  - state EMPTY, `o_valid`=0, `o_ready`=1
  - `o_data`, `o_ctrl`, `o_pc`, `o_epc` = 0
  - `o_epc_valid`=0, `o_count`=0
- Reset mid-operation discards both slots immediately; no EPC pulse.
- Latency: input accepted at edge N appears on the outputs after edge N (one cycle) when the stage was EMPTY, or ONE with a take.
- Throughput: one instruction per cycle with `i_ready`=1.
- Skid entry: forwarded one cycle after the take that frees main.
- `o_ready` falls in the cycle after the state enters TWO. Upstream may present `i_valid` while `o_ready`=0; that data is not consumed and must be held.
- Outputs remain stable while `o_valid`=1 and `i_ready`=0.
- Flush in cycle N: outputs show a bubble after edge N. `o_ready`=1 after edge N.

## Test plan

- Reset: assert `i_rst_n`=0 mid-stream with count=2 → all outputs zero, `o_ready`=1, `o_count`=0, no `o_epc_valid`.
- Streaming: `i_valid`=1 and `i_ready`=1 for 8 cycles, PCs 0x100..0x11C → same PCs and payloads on the outputs, one cycle later, in order, with no gaps.
- Backpressure: `i_ready`=0 while feeding PCs 0x200, 0x204, 0x208 → `o_count` reaches 2, `o_ready`=0, 0x208 is held upstream. Release `i_ready` → order 0x200, 0x204, 0x208 with no loss or duplication.
- Flush with occupancy: count=2 (0x300, 0x304), assert `i_flush` with `i_valid`=1 (0x308) → next cycle `o_valid`=0, `o_ctrl`=0, `o_epc`=0x300, `o_epc_valid`=1 for exactly one cycle, 0x308 dropped.
- Flush when empty: `i_flush`=1 at count=0 → `o_epc_valid` stays 0 and `o_epc` is unchanged.
- Bubble: `i_valid`=0 with `i_ctrl`=all-ones → `o_ctrl`=0. With `ZERO_DATA`=0, `o_data` holds its previous value.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid.
// slave is the stage's view, master the surrounding pipeline's view.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 95,
  parameter int CTRL_W = 13,
  parameter int PC_W   = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic [PC_W-1:0]   i_pc;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic [PC_W-1:0]   o_pc;
  logic              i_flush;
  logic [PC_W-1:0]   o_epc;
  logic              o_epc_valid;
  logic [1:0]        o_count;

  modport slave (
    input  i_valid, i_data, i_ctrl, i_pc,
    input  i_ready, i_flush,
    output o_ready, o_valid, o_data, o_ctrl,
    output o_pc, o_epc, o_epc_valid, o_count
  );

  modport master (
    output i_valid, i_data, i_ctrl, i_pc,
    output i_ready, i_flush,
    input  o_ready, o_valid, o_data, o_ctrl,
    input  o_pc, o_epc, o_epc_valid, o_count
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with one-entry skid buffer,
// synchronous flush and exception-PC capture.
module pipe_stage_skid #(
  parameter int DATA_W    = 95,
  parameter int CTRL_W    = 13,
  parameter int PC_W      = 32,
  parameter bit ZERO_DATA = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  pipe_stage_skid_if.slave s
);

  // encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [CTRL_W-1:0] mctrl_q, mctrl_d;
  logic [PC_W-1:0]   mpc_q, mpc_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [CTRL_W-1:0] sctrl_q, sctrl_d;
  logic [PC_W-1:0]   spc_q, spc_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic              epcv_q, epcv_d;

  logic              accept;
  logic              take;
  logic [DATA_W-1:0] bub_data;

  assign accept   = s.i_valid & (state_q != TWO);
  assign take     = (state_q != EMPTY) & s.i_ready;
  assign bub_data = ZERO_DATA ? '0 : mdata_q;

  always_comb begin
    state_d = state_q;
    mdata_d = mdata_q;
    mctrl_d = mctrl_q;
    mpc_d   = mpc_q;
    sdata_d = sdata_q;
    sctrl_d = sctrl_q;
    spc_d   = spc_q;
    epc_d   = epc_q;
    epcv_d  = 1'b0;
    if (s.i_flush) begin
      state_d = EMPTY;
      mctrl_d = '0;
      mdata_d = bub_data;
      if (state_q != EMPTY) begin
        epc_d  = mpc_q;
        epcv_d = 1'b1;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            mdata_d = s.i_data;
            mctrl_d = s.i_ctrl;
            mpc_d   = s.i_pc;
          end
        end
        ONE: begin
          if (accept && take) begin
            mdata_d = s.i_data;
            mctrl_d = s.i_ctrl;
            mpc_d   = s.i_pc;
          end else if (accept) begin
            state_d = TWO;
            sdata_d = s.i_data;
            sctrl_d = s.i_ctrl;
            spc_d   = s.i_pc;
          end else if (take) begin
            state_d = EMPTY;
            mctrl_d = '0;
            mdata_d = bub_data;
          end
        end
        TWO: begin
          if (take) begin
            state_d = ONE;
            mdata_d = sdata_q;
            mctrl_d = sctrl_q;
            mpc_d   = spc_q;
          end
        end
        default: begin
          state_d = EMPTY;
          mctrl_d = '0;
          mdata_d = bub_data;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      mdata_q <= '0;
      mctrl_q <= '0;
      mpc_q   <= '0;
      sdata_q <= '0;
      sctrl_q <= '0;
      spc_q   <= '0;
      epc_q   <= '0;
      epcv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mdata_q <= mdata_d;
      mctrl_q <= mctrl_d;
      mpc_q   <= mpc_d;
      sdata_q <= sdata_d;
      sctrl_q <= sctrl_d;
      spc_q   <= spc_d;
      epc_q   <= epc_d;
      epcv_q  <= epcv_d;
    end
  end

  assign s.o_ready     = (state_q != TWO);
  assign s.o_valid     = (state_q != EMPTY);
  assign s.o_count     = state_q;
  assign s.o_data      = mdata_q;
  assign s.o_ctrl      = mctrl_q;
  assign s.o_pc        = mpc_q;
  assign s.o_epc       = epc_q;
  assign s.o_epc_valid = epcv_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random
// traffic, checked against a queue model of the stage.
module tb_pipe_stage_skid;
  localparam int DW = 95;
  localparam int CW = 13;
  localparam int PW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [PW-1:0] pc;
  } ent_t;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nfail;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW), .PC_W(PW)) bz ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW), .PC_W(PW)) bh ();

  assign bh.i_valid = bz.i_valid;
  assign bh.i_data  = bz.i_data;
  assign bh.i_ctrl  = bz.i_ctrl;
  assign bh.i_pc    = bz.i_pc;
  assign bh.i_ready = bz.i_ready;
  assign bh.i_flush = bz.i_flush;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .PC_W(PW), .ZERO_DATA(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .s(bz)
  );

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .PC_W(PW), .ZERO_DATA(1'b0)
  ) dut_h (
    .i_clk(clk), .i_rst_n(rst_n), .s(bh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: FIFO of at most two entries
  ent_t          mq[$];
  logic [DW-1:0] m_lastd;
  logic [PW-1:0] m_lastpc;
  logic [PW-1:0] m_epc;
  bit            m_epcv;

  task automatic model_reset();
    mq.delete();
    m_lastd  = '0;
    m_lastpc = '0;
    m_epc    = '0;
    m_epcv   = 1'b0;
  endtask

  task automatic model_step(bit v, ent_t e, bit rdy, bit fl);
    bit acc;
    bit tk;
    acc = v && (mq.size() < 2);
    tk  = (mq.size() > 0) && rdy;
    if (fl) begin
      m_epcv = (mq.size() > 0);
      if (m_epcv) m_epc = mq[0].pc;
      mq.delete();
    end else begin
      m_epcv = 1'b0;
      if (tk) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    if (mq.size() > 0) begin
      m_lastd  = mq[0].d;
      m_lastpc = mq[0].pc;
    end
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit            ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [DW-1:0] edh;
    logic [PW-1:0] ep;
    ev  = (mq.size() > 0);
    ec  = ev ? mq[0].c  : '0;
    ed  = ev ? mq[0].d  : '0;
    edh = ev ? mq[0].d  : m_lastd;
    ep  = ev ? mq[0].pc : m_lastpc;
    chk("o_valid", 128'(bz.o_valid), 128'(ev));
    chk("o_ready", 128'(bz.o_ready), 128'(mq.size() < 2));
    chk("o_count", 128'(bz.o_count), 128'(mq.size()));
    chk("o_ctrl", 128'(bz.o_ctrl), 128'(ec));
    chk("o_data", 128'(bz.o_data), 128'(ed));
    chk("o_pc", 128'(bz.o_pc), 128'(ep));
    chk("o_epc", 128'(bz.o_epc), 128'(m_epc));
    chk("o_epc_valid", 128'(bz.o_epc_valid), 128'(m_epcv));
    chk("hold o_data", 128'(bh.o_data), 128'(edh));
    chk("hold o_ctrl", 128'(bh.o_ctrl), 128'(ec));
    chk("hold o_pc", 128'(bh.o_pc), 128'(ep));
  endtask

  function automatic ent_t rnd_ent(logic [PW-1:0] pc);
    ent_t e;
    e.d  = DW'({$urandom, $urandom, $urandom});
    e.c  = CW'($urandom);
    e.pc = pc;
    return e;
  endfunction

  task automatic step(bit v, ent_t e, bit rdy, bit fl);
    bz.i_valid = v;
    bz.i_data  = e.d;
    bz.i_ctrl  = e.c;
    bz.i_pc    = e.pc;
    bz.i_ready = rdy;
    bz.i_flush = fl;
    @(posedge clk);
    model_step(v, e, rdy, fl);
    #1;
    check_all();
  endtask

  ent_t          e;
  ent_t          bub;
  logic [DW-1:0] saved_d;

  initial begin
    ncmp  = 0;
    nfail = 0;
    model_reset();
    rst_n      = 1'b0;
    bz.i_valid = 1'b0;
    bz.i_data  = '0;
    bz.i_ctrl  = '0;
    bz.i_pc    = '0;
    bz.i_ready = 1'b0;
    bz.i_flush = 1'b0;
    #12;
    check_all();
    rst_n = 1'b1;

    // streaming, one per cycle
    for (int i = 0; i < 8; i++)
      step(1'b1, rnd_ent(PW'(32'h100 + 4 * i)), 1'b1, 1'b0);
    chk("stream last pc", 128'(bz.o_pc), 128'(32'h11C));
    e = rnd_ent('0);
    step(1'b0, e, 1'b1, 1'b0);

    // backpressure: 0x208 held upstream until accepted
    step(1'b1, rnd_ent(32'h200), 1'b0, 1'b0);
    step(1'b1, rnd_ent(32'h204), 1'b0, 1'b0);
    chk("bp count", 128'(bz.o_count), 128'(2));
    chk("bp ready", 128'(bz.o_ready), 128'(0));
    e = rnd_ent(32'h208);
    step(1'b1, e, 1'b0, 1'b0);
    chk("bp stall pc", 128'(bz.o_pc), 128'(32'h200));
    step(1'b1, e, 1'b1, 1'b0);
    chk("bp drain 204", 128'(bz.o_pc), 128'(32'h204));
    step(1'b1, e, 1'b1, 1'b0);
    chk("bp drain 208", 128'(bz.o_pc), 128'(32'h208));
    step(1'b0, e, 1'b1, 1'b0);
    chk("bp empty", 128'(bz.o_valid), 128'(0));

    // flush with two entries
    step(1'b1, rnd_ent(32'h300), 1'b0, 1'b0);
    step(1'b1, rnd_ent(32'h304), 1'b0, 1'b0);
    step(1'b1, rnd_ent(32'h308), 1'b0, 1'b1);
    chk("flush epc", 128'(bz.o_epc), 128'(32'h300));
    chk("flush epcv", 128'(bz.o_epc_valid), 128'(1));
    chk("flush valid", 128'(bz.o_valid), 128'(0));
    step(1'b0, e, 1'b1, 1'b0);
    chk("flush pulse end", 128'(bz.o_epc_valid), 128'(0));

    // flush while empty
    step(1'b0, e, 1'b1, 1'b1);
    chk("eflush epcv", 128'(bz.o_epc_valid), 128'(0));
    chk("eflush epc", 128'(bz.o_epc), 128'(32'h300));

    // bubble with all-ones control on the input
    step(1'b1, rnd_ent(32'h400), 1'b0, 1'b0);
    saved_d = bh.o_data;
    bub   = rnd_ent(32'h404);
    bub.c = '1;
    step(1'b0, bub, 1'b1, 1'b0);
    chk("bubble ctrl", 128'(bz.o_ctrl), 128'(0));
    chk("bubble hold data", 128'(bh.o_data), 128'(saved_d));

    // random traffic; pending item held until consumed
    e = rnd_ent(PW'($urandom));
    for (int i = 0; i < 400; i++) begin
      bit v, rdy, fl, used;
      v    = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      used = fl || (v && mq.size() < 2);
      step(v, e, rdy, fl);
      if (used) e = rnd_ent(PW'($urandom));
    end

    // asynchronous reset with two entries
    step(1'b0, e, 1'b1, 1'b1);
    step(1'b1, rnd_ent(32'h500), 1'b0, 1'b0);
    step(1'b1, rnd_ent(32'h504), 1'b0, 1'b0);
    chk("pre-rst count", 128'(bz.o_count), 128'(2));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst epcv", 128'(bz.o_epc_valid), 128'(0));
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(1'b1, rnd_ent(PW'(32'h600 + 4 * i)), 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end
endmodule
